stk_pipe_wrbk: RTL and testbench

Writeback stage of the stk pipeline, directly downstream of the memory stage. Consumes the WRBK microcode the memory stage produces and commits per-engine context state (empty flag, head pointer, tail pointer) into a register-based state table. Provides a forwarded lookup read port to the upstream LK stage and emits empty-transition events. Runs an initialisation sweep of the table after reset.

---
 rtl/stk_pkg.sv | 65 ++++++
 rtl/stk_pipe_wrbk_fwd.sv | 40 ++++
 rtl/stk_pipe_wrbk.sv | 187 ++++++++++++++++++
 tb/tb_stk_pipe_wrbk.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stk_pkg
// Purpose : Shared types and constants for the stk pipeline. Provides engine
//           id and pointer types, the WRBK microcode word produced by the
//           memory stage, the per-engine context record, the writeback FSM
//           state encoding and the field-wise microcode apply function.
// Revision: 1.0 - initial release
// ============================================================================
package stk_pkg;

  localparam int ENGS_N  = 4;
  localparam int ENGID_W = 2;
  localparam int PTR_W   = 16;

  typedef logic [ENGID_W-1:0] engid_t;
  typedef logic [PTR_W-1:0]   ptr_t;

  // WRBK microcode word, produced by stk_pipe_mem
  typedef struct packed {
    logic   vld;
    engid_t engid;
    logic   set_empty;
    logic   clr_empty;
    logic   head_vld;
    ptr_t   head_ptr;
    logic   tail_vld;
    ptr_t   tail_ptr;
  } wrbk_uc_t;

  // Per-engine context held in the writeback state table
  typedef struct packed {
    logic empty;
    ptr_t head;
    ptr_t tail;
  } ctx_t;

  typedef enum logic [0:0] {
    WRBK_ST_INIT  = 1'b0,
    WRBK_ST_READY = 1'b1
  } wrbk_state_e;

  // Apply one microcode word on top of a context. Only the fields whose
  // valid bit is set change. A simultaneous set/clr of the empty flag is a
  // conflict and leaves the flag at its older value; pointers still apply.
  // The vld/engid fields are not examined here; callers qualify the match.
  function automatic ctx_t wrbk_apply(ctx_t base, wrbk_uc_t uc);
    ctx_t r;
    r = base;
    if (uc.set_empty && !uc.clr_empty) begin
      r.empty = 1'b1;
    end else if (uc.clr_empty && !uc.set_empty) begin
      r.empty = 1'b0;
    end
    if (uc.head_vld) begin
      r.head = uc.head_ptr;
    end
    if (uc.tail_vld) begin
      r.tail = uc.tail_ptr;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stk_pipe_wrbk_fwd.sv
`default_nettype none
// ============================================================================
// Module  : stk_pipe_wrbk_fwd
// Purpose : Combinational forwarding merge for the writeback state table.
//           Starts from the stored table entry, overlays the registered
//           microcode (uc_r) and then the live microcode (_w) when their
//           engine ids match the lookup. Youngest data wins per field.
// Ports   : i_entry     - table entry for the looked-up engine
//           i_uc_r      - registered microcode (older)
//           i_uc_w      - live microcode (younger)
//           i_w_en      - live microcode may be forwarded (stage ready)
//           i_lk_engid  - engine being looked up
//           o_ctx       - merged context
// Revision: 1.0 - initial release
// ============================================================================
module stk_pipe_wrbk_fwd (
  input  stk_pkg::ctx_t     i_entry,
  input  stk_pkg::wrbk_uc_t i_uc_r,
  input  stk_pkg::wrbk_uc_t i_uc_w,
  input  logic              i_w_en,
  input  stk_pkg::engid_t   i_lk_engid,
  output stk_pkg::ctx_t     o_ctx
);
  import stk_pkg::*;

  ctx_t w_mid;

  always_comb begin
    w_mid = i_entry;
    if (i_uc_r.vld && (i_uc_r.engid == i_lk_engid)) begin
      w_mid = wrbk_apply(i_entry, i_uc_r);
    end
    o_ctx = w_mid;
    if (i_w_en && i_uc_w.vld && (i_uc_w.engid == i_lk_engid)) begin
      o_ctx = wrbk_apply(w_mid, i_uc_w);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stk_pipe_wrbk.sv
`default_nettype none
// ============================================================================
// Module  : stk_pipe_wrbk
// Purpose : Writeback stage of the stk pipeline. Registers WRBK microcode
//           from the memory stage, commits it one cycle later into a
//           per-engine context table (empty flag, head, tail), emits empty
//           transition events, and serves a forwarded lookup to the LK stage.
//           After reset the table is swept to empty/0/0 while o_busy_r is
//           high; microcode seen during the sweep is dropped and flagged.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           i_wrbk_uc_*_w            - live WRBK microcode fields
//           i_lk_engid, o_lk_*       - forwarded lookup port
//           o_evt_*_r                - empty-flag change event (1-cycle pulse)
//           o_busy_r                 - initialisation sweep in progress
//           o_err_r                  - sticky protocol error
//           o_commit_cnt_r           - committed microcode count (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module stk_pipe_wrbk #(
  parameter int ENGS_N = stk_pkg::ENGS_N,
  parameter int PTR_W  = $bits(stk_pkg::ptr_t),
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wrbk_uc_vld_w,
  input  stk_pkg::engid_t      i_wrbk_uc_engid_w,
  input  logic                 i_wrbk_uc_set_empty_w,
  input  logic                 i_wrbk_uc_clr_empty_w,
  input  logic                 i_wrbk_uc_head_vld_w,
  input  logic [PTR_W-1:0]     i_wrbk_uc_head_ptr_w,
  input  logic                 i_wrbk_uc_tail_vld_w,
  input  logic [PTR_W-1:0]     i_wrbk_uc_tail_ptr_w,
  input  stk_pkg::engid_t      i_lk_engid,
  output logic                 o_lk_empty,
  output logic [PTR_W-1:0]     o_lk_head_ptr,
  output logic [PTR_W-1:0]     o_lk_tail_ptr,
  output logic                 o_evt_vld_r,
  output stk_pkg::engid_t      o_evt_engid_r,
  output logic                 o_evt_empty_r,
  output logic                 o_busy_r,
  output logic                 o_err_r,
  output logic [CNT_W-1:0]     o_commit_cnt_r
);
  import stk_pkg::*;

  localparam engid_t LAST_IDX = engid_t'(ENGS_N - 1);

  wrbk_state_e      state_q, state_d;
  engid_t           init_idx_q, init_idx_d;
  wrbk_uc_t         uc_q;
  ctx_t             table_q [ENGS_N];
  logic             busy_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             evt_vld_q;
  engid_t           evt_engid_q;
  logic             evt_empty_q;

  logic             w_ready;
  wrbk_uc_t         w_uc_in;
  ctx_t             w_old;
  ctx_t             w_commit;
  ctx_t             w_lk_ctx;

  assign w_ready = (state_q == WRBK_ST_READY);

  // Live microcode, valid only once the sweep is over; anything earlier is
  // discarded here so it can neither register nor forward.
  always_comb begin
    w_uc_in           = '0;
    w_uc_in.vld       = i_wrbk_uc_vld_w && w_ready;
    w_uc_in.engid     = i_wrbk_uc_engid_w;
    w_uc_in.set_empty = i_wrbk_uc_set_empty_w;
    w_uc_in.clr_empty = i_wrbk_uc_clr_empty_w;
    w_uc_in.head_vld  = i_wrbk_uc_head_vld_w;
    w_uc_in.head_ptr  = i_wrbk_uc_head_ptr_w;
    w_uc_in.tail_vld  = i_wrbk_uc_tail_vld_w;
    w_uc_in.tail_ptr  = i_wrbk_uc_tail_ptr_w;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WRBK_ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      WRBK_ST_INIT: begin
        init_idx_d = engid_t'(init_idx_q + engid_t'(1));
        if (init_idx_q == LAST_IDX) begin
          state_d = WRBK_ST_READY;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // ------------------------------------------------------- commit path
  assign w_old    = table_q[uc_q.engid];
  assign w_commit = wrbk_apply(w_old, uc_q);

  // Table is datapath only: its contents are defined by the sweep, so it
  // carries no reset. Writes are held off while rst is asserted so a
  // pending uc_r is discarded rather than committed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == WRBK_ST_INIT) begin
        table_q[init_idx_q] <= '{empty: 1'b1, head: '0, tail: '0};
      end else if (uc_q.vld) begin
        table_q[uc_q.engid] <= w_commit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uc_q        <= '0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      evt_vld_q   <= 1'b0;
      evt_engid_q <= '0;
      evt_empty_q <= 1'b0;
    end else begin
      uc_q      <= w_uc_in;
      busy_q    <= (state_d == WRBK_ST_INIT);
      evt_vld_q <= 1'b0;
      if (i_wrbk_uc_vld_w && !w_ready) begin
        err_q <= 1'b1;
      end
      if (uc_q.vld) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (uc_q.set_empty && uc_q.clr_empty) begin
          err_q <= 1'b1;
        end
        if (w_commit.empty != w_old.empty) begin
          evt_vld_q   <= 1'b1;
          evt_engid_q <= uc_q.engid;
          evt_empty_q <= w_commit.empty;
        end
      end
    end
  end

  // ------------------------------------------------------- lookup port
  stk_pipe_wrbk_fwd u_fwd (
    .i_entry    (table_q[i_lk_engid]),
    .i_uc_r     (uc_q),
    .i_uc_w     (w_uc_in),
    .i_w_en     (w_ready),
    .i_lk_engid (i_lk_engid),
    .o_ctx      (w_lk_ctx)
  );

  assign o_lk_empty    = w_lk_ctx.empty;
  assign o_lk_head_ptr = w_lk_ctx.head;
  assign o_lk_tail_ptr = w_lk_ctx.tail;

  assign o_evt_vld_r    = evt_vld_q;
  assign o_evt_engid_r  = evt_engid_q;
  assign o_evt_empty_r  = evt_empty_q;
  assign o_busy_r       = busy_q;
  assign o_err_r        = err_q;
  assign o_commit_cnt_r = cnt_q;

`ifndef SYNTHESIS
  // Lookups of engines beyond the table size are illegal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(i_lk_engid) < ENGS_N);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stk_pipe_wrbk.sv
`default_nettype none
// ============================================================================
// Module  : tb_stk_pipe_wrbk
// Purpose : Self-checking bench for stk_pipe_wrbk. Expected empty-transition
//           events are queued when microcode is driven and popped when the
//           DUT raises o_evt_vld_r; each scenario task checks its own
//           lookup, counter, busy and error expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stk_pipe_wrbk;
  import stk_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uc_vld = 1'b0;
  engid_t      uc_engid = '0;
  logic        uc_set = 1'b0;
  logic        uc_clr = 1'b0;
  logic        uc_hv = 1'b0;
  ptr_t        uc_hp = '0;
  logic        uc_tv = 1'b0;
  ptr_t        uc_tp = '0;
  engid_t      lk_engid = '0;
  logic        lk_empty;
  ptr_t        lk_head;
  ptr_t        lk_tail;
  logic        evt_vld;
  engid_t      evt_engid;
  logic        evt_empty;
  logic        busy;
  logic        err;
  logic [31:0] cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = '0;
  logic [2:0]  evt_q [$];
  logic [2:0]  evt_exp;

  always #5 clk = ~clk;

  stk_pipe_wrbk #(.ENGS_N(4), .PTR_W(16), .CNT_W(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_wrbk_uc_vld_w       (uc_vld),
    .i_wrbk_uc_engid_w     (uc_engid),
    .i_wrbk_uc_set_empty_w (uc_set),
    .i_wrbk_uc_clr_empty_w (uc_clr),
    .i_wrbk_uc_head_vld_w  (uc_hv),
    .i_wrbk_uc_head_ptr_w  (uc_hp),
    .i_wrbk_uc_tail_vld_w  (uc_tv),
    .i_wrbk_uc_tail_ptr_w  (uc_tp),
    .i_lk_engid            (lk_engid),
    .o_lk_empty            (lk_empty),
    .o_lk_head_ptr         (lk_head),
    .o_lk_tail_ptr         (lk_tail),
    .o_evt_vld_r           (evt_vld),
    .o_evt_engid_r         (evt_engid),
    .o_evt_empty_r         (evt_empty),
    .o_busy_r              (busy),
    .o_err_r               (err),
    .o_commit_cnt_r        (cnt)
  );

  // Event scoreboard: every event the DUT raises must match the oldest
  // expected one.
  always @(negedge clk) begin
    if (evt_vld === 1'b1) begin
      n_tests++;
      if (evt_q.size() == 0) begin
        n_fail++;
        $display("FAIL evt_unexpected: got engid=%0d empty=%b, want no event", evt_engid, evt_empty);
      end else begin
        evt_exp = evt_q.pop_front();
        if ({evt_engid, evt_empty} !== evt_exp) begin
          n_fail++;
          $display("FAIL evt_content: got engid=%0d empty=%b, want engid=%0d empty=%b",
                   evt_engid, evt_empty, evt_exp[2:1], evt_exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uc(input engid_t e, input logic s, input logic c,
                          input logic hv, input ptr_t hp, input logic tv, input ptr_t tp);
    uc_vld = 1'b1; uc_engid = e; uc_set = s; uc_clr = c;
    uc_hv = hv; uc_hp = hp; uc_tv = tv; uc_tp = tp;
  endtask

  task automatic idle_uc();
    uc_vld = 1'b0; uc_engid = '0; uc_set = 1'b0; uc_clr = 1'b0;
    uc_hv = 1'b0; uc_hp = '0; uc_tv = 1'b0; uc_tp = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_timeout: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_uc(); lk_engid = '0;
    repeat (3) tick();
    n_tests++;
    if ({busy, err, evt_vld, cnt} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b err=%b evt=%b cnt=%0d, want 1 0 0 0", busy, err, evt_vld, cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL busy_sweep[%0d]: got %b want %b", i, busy, (i < 4));
      end
    end
    for (int e = 0; e < 4; e++) begin
      lk_engid = engid_t'(e);
      #1;
      n_tests++;
      if ({lk_empty, lk_head, lk_tail} !== {1'b1, 16'h0000, 16'h0000}) begin
        n_fail++;
        $display("FAIL init_lookup[%0d]: got empty=%b head=%h tail=%h, want 1 0000 0000", e, lk_empty, lk_head, lk_tail);
      end
    end
    tick();
  endtask

  task automatic test_busy_drop();
    rst = 1'b1; idle_uc();
    repeat (2) tick();
    rst = 1'b0; exp_cnt = '0;
    drive_uc(2'd2, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    idle_uc();
    wait_ready();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_drop_err: got %b want 1", err);
    end
    lk_engid = 2'd2; #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail, cnt} !== {1'b1, 16'h0, 16'h0, 32'd0}) begin
      n_fail++;
      $display("FAIL busy_drop_eng2: got empty=%b head=%h tail=%h cnt=%0d, want 1 0000 0000 0", lk_empty, lk_head, lk_tail, cnt);
    end
  endtask

  task automatic test_commit();
    drive_uc(2'd1, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0010);
    evt_q.push_back({2'd1, 1'b0}); exp_cnt++;
    lk_engid = 2'd1; #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail} !== {1'b0, 16'h0010, 16'h0010}) begin
      n_fail++;
      $display("FAIL fwd_live: got empty=%b head=%h tail=%h, want 0 0010 0010", lk_empty, lk_head, lk_tail);
    end
    tick(); idle_uc(); #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail, cnt} !== {1'b0, 16'h0010, 16'h0010, exp_cnt - 32'd1}) begin
      n_fail++;
      $display("FAIL fwd_ucr: got empty=%b head=%h tail=%h cnt=%0d, want 0 0010 0010 %0d", lk_empty, lk_head, lk_tail, cnt, exp_cnt - 32'd1);
    end
    tick();
    n_tests++;
    if ({lk_empty, lk_head, lk_tail, cnt, evt_vld, evt_engid, evt_empty} !==
        {1'b0, 16'h0010, 16'h0010, exp_cnt, 1'b1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL commit_eng1: got empty=%b head=%h tail=%h cnt=%0d evt=%b/%0d/%b, want 0 0010 0010 %0d 1/1/0",
               lk_empty, lk_head, lk_tail, cnt, evt_vld, evt_engid, evt_empty, exp_cnt);
    end
    // non-empty -> empty produces an event
    drive_uc(2'd1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    evt_q.push_back({2'd1, 1'b1}); exp_cnt++;
    tick(); idle_uc(); tick();
    n_tests++;
    if ({lk_empty, lk_head, lk_tail, cnt} !== {1'b1, 16'h0010, 16'h0010, exp_cnt}) begin
      n_fail++;
      $display("FAIL set_empty_eng1: got empty=%b head=%h tail=%h cnt=%0d, want 1 0010 0010 %0d", lk_empty, lk_head, lk_tail, cnt, exp_cnt);
    end
    // already-empty engine: counted, no event
    drive_uc(2'd2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    exp_cnt++;
    tick(); idle_uc(); tick(); tick();
    n_tests++;
    if (cnt !== exp_cnt || evt_q.size() != 0) begin
      n_fail++;
      $display("FAIL set_already_empty: got cnt=%0d pending_evts=%0d, want %0d 0", cnt, evt_q.size(), exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive_uc(2'd3, 1'b0, 1'b0, 1'b1, 16'h0033, 1'b1, 16'h0005);
    exp_cnt++;
    tick();
    drive_uc(2'd3, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0006);
    exp_cnt++;
    lk_engid = 2'd3; #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail} !== {1'b1, 16'h0033, 16'h0006}) begin
      n_fail++;
      $display("FAIL b2b_fwd: got empty=%b head=%h tail=%h, want 1 0033 0006", lk_empty, lk_head, lk_tail);
    end
    tick(); idle_uc(); #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail} !== {1'b1, 16'h0033, 16'h0006}) begin
      n_fail++;
      $display("FAIL b2b_ucr: got empty=%b head=%h tail=%h, want 1 0033 0006", lk_empty, lk_head, lk_tail);
    end
    tick();
    n_tests++;
    if ({lk_empty, lk_head, lk_tail, cnt} !== {1'b1, 16'h0033, 16'h0006, exp_cnt}) begin
      n_fail++;
      $display("FAIL b2b_table: got empty=%b head=%h tail=%h cnt=%0d, want 1 0033 0006 %0d", lk_empty, lk_head, lk_tail, cnt, exp_cnt);
    end
  endtask

  task automatic test_conflict();
    rst = 1'b1; idle_uc();
    repeat (2) tick();
    rst = 1'b0; exp_cnt = '0;
    wait_ready();
    drive_uc(2'd0, 1'b1, 1'b1, 1'b1, 16'h00AA, 1'b0, 16'h0);
    exp_cnt++;
    lk_engid = 2'd0; #1;
    n_tests++;
    if ({lk_empty, lk_head, lk_tail} !== {1'b1, 16'h00AA, 16'h0000}) begin
      n_fail++;
      $display("FAIL conflict_fwd: got empty=%b head=%h tail=%h, want 1 00aa 0000", lk_empty, lk_head, lk_tail);
    end
    tick(); idle_uc(); tick();
    n_tests++;
    if ({err, lk_empty, lk_head, lk_tail, cnt} !== {1'b1, 1'b1, 16'h00AA, 16'h0000, exp_cnt}) begin
      n_fail++;
      $display("FAIL conflict_commit: got err=%b empty=%b head=%h tail=%h cnt=%0d, want 1 1 00aa 0000 %0d",
               err, lk_empty, lk_head, lk_tail, cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    // Reset lands on the commit edge of a pending microcode: discarded.
    drive_uc(2'd1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();
    idle_uc(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    // Sweep index is now 2; restart it.
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL midreset_busy[%0d]: got %b want %b", i, busy, (i < 4));
      end
    end
    lk_engid = 2'd1; #1;
    n_tests++;
    if ({cnt, err, lk_empty, lk_head, lk_tail} !== {32'd0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset_state: got cnt=%0d err=%b empty=%b head=%h tail=%h, want 0 0 1 0000 0000",
               cnt, err, lk_empty, lk_head, lk_tail);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_busy_drop();
    test_commit();
    test_back_to_back();
    test_conflict();
    test_mid_reset();
    tick(); tick();
    n_tests++;
    if (evt_q.size() != 0) begin
      n_fail++;
      $display("FAIL evt_missing: got %0d events still pending, want 0", evt_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
